// File: rtl/execute_multicycle.sv
// execute_multicycle: handshaked execute stage. It runs the single-cycle ALU,
// compare, bit-reverse and byte-load operations, plus an iterative shift-add
// multiply. Define EXEC_DIV_EN to also build the iterative restoring divider.
// Without EXEC_DIV_EN, DIV completes in one cycle with XOut=0 and err=1.
//
// state | meaning
// IDLE  | accepting; single-cycle ops write the output register directly
// ITER  | one multiply/divide step per cycle, counter counts down to 1
// DONE  | iterative result waits for a free output slot
module execute_multicycle #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] read1Data,
  input  logic [WIDTH-1:0] read2Data,
  input  logic [WIDTH-1:0] immediateExt,
  input  logic             srcALU,
  input  logic [2:0]       xOp,
  input  logic             cmpSet,
  input  logic [1:0]       cmpOp,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] XOut,
  output logic             err,
  output logic             busy
);

  localparam int HALF = WIDTH / 2;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] ITER_COUNT = CW'(WIDTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] regA;   // multiplicand, or dividend shifting into quotient
  logic [WIDTH-1:0] regB;   // multiplier, or divisor
  logic [WIDTH-1:0] acc;    // product, or partial remainder
`ifdef EXEC_DIV_EN
  logic             isDiv;
`endif

  logic [WIDTH-1:0] opB;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;
  logic             negFlag, ovfFlag, zeroFlag, cmpBit;
  logic [WIDTH-1:0] btrResult;
  logic [WIDTH-1:0] scResult;
  logic             scErr, scMulti;
  logic [WIDTH-1:0] mulAcc;
  logic [WIDTH-1:0] doneResult;
  logic             accept, slotFree, writeOut;
  logic [WIDTH-1:0] writeData;
  logic             writeErr;

  assign opB      = srcALU ? immediateExt : read2Data;
  assign sum      = {1'b0, read1Data} + {1'b0, opB};
  assign diff     = read1Data - opB;
  assign negFlag  = diff[WIDTH-1];
  assign ovfFlag  = (read1Data[WIDTH-1] ^ opB[WIDTH-1]) & (diff[WIDTH-1] ^ read1Data[WIDTH-1]);
  assign zeroFlag = (diff == '0);

  // Compare bit selected by cmpOp; signed compares come from the A-B flags.
  always_comb begin
    cmpBit = 1'b0;
    case (cmpOp)
      2'b00:   cmpBit = zeroFlag;
      2'b01:   cmpBit = negFlag ^ ovfFlag;
      2'b10:   cmpBit = (negFlag ^ ovfFlag) | zeroFlag;
      default: cmpBit = sum[WIDTH];
    endcase
  end

  // Bit reversal of operand A.
  always_comb begin
    btrResult = '0;
    for (int i = 0; i < WIDTH; i++) btrResult[i] = read1Data[WIDTH-1-i];
  end

  // Single-cycle result and the decision to start an iterative op.
  always_comb begin
    scResult = '0;
    scErr    = 1'b0;
    scMulti  = 1'b0;
    if (cmpSet) begin
      scResult = {{(WIDTH-1){1'b0}}, cmpBit};
    end else begin
      case (xOp)
        3'b000:  scResult = sum[WIDTH-1:0];
        3'b001:  scResult = diff;
        3'b010:  scResult = read1Data & opB;
        3'b011:  scResult = read1Data ^ opB;
        3'b100:  scResult = btrResult;
        3'b101:  scResult = {read1Data[HALF-1:0], immediateExt[HALF-1:0]};
        3'b110:  scMulti  = 1'b1;
        default: begin
`ifdef EXEC_DIV_EN
          if (opB == '0) begin
            scResult = '1;
            scErr    = 1'b1;
          end else begin
            scMulti  = 1'b1;
          end
`else
          scErr = 1'b1;
`endif
        end
      endcase
    end
  end

  assign mulAcc = acc + (regB[0] ? regA : '0);

`ifdef EXEC_DIV_EN
  logic [WIDTH:0]   remShift;
  logic [WIDTH:0]   trial;
  logic             trialOk;
  logic [WIDTH-1:0] newRem;

  // Restoring step: shift in the next dividend bit, subtract if it fits.
  assign remShift   = {acc, regA[WIDTH-1]};
  assign trial      = remShift - {1'b0, regB};
  assign trialOk    = !trial[WIDTH];
  assign newRem     = trialOk ? trial[WIDTH-1:0] : remShift[WIDTH-1:0];
  assign doneResult = isDiv ? regA : acc;
`else
  assign doneResult = acc;
`endif

  assign inReady   = !rst && (state == IDLE) && (!outValid || outReady);
  assign busy      = (state != IDLE);
  assign accept    = inValid && inReady;
  assign slotFree  = !outValid || outReady;
  assign writeOut  = (accept && !scMulti) || ((state == DONE) && slotFree);
  assign writeData = (state == DONE) ? doneResult : scResult;
  assign writeErr  = (state == DONE) ? 1'b0 : scErr;

  // Sequencer and iterative datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      count <= '0;
      regA  <= '0;
      regB  <= '0;
      acc   <= '0;
`ifdef EXEC_DIV_EN
      isDiv <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept && scMulti) begin
            state <= ITER;
            count <= ITER_COUNT;
            regA  <= read1Data;
            regB  <= opB;
            acc   <= '0;
`ifdef EXEC_DIV_EN
            isDiv <= xOp[0];
`endif
          end
        end
        ITER: begin
          count <= count - CW'(1);
`ifdef EXEC_DIV_EN
          if (isDiv) begin
            acc  <= newRem;
            regA <= {regA[WIDTH-2:0], trialOk};
          end else begin
            acc  <= mulAcc;
            regA <= regA << 1;
            regB <= regB >> 1;
          end
`else
          acc  <= mulAcc;
          regA <= regA << 1;
          regB <= regB >> 1;
`endif
          if (count == CW'(1)) state <= DONE;
        end
        DONE: begin
          if (slotFree) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: a write wins over a drain in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      outValid <= 1'b0;
      XOut     <= '0;
      err      <= 1'b0;
    end else if (writeOut) begin
      outValid <= 1'b1;
      XOut     <= writeData;
      err      <= writeErr;
    end else if (outValid && outReady) begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_multicycle.sv
module tb_execute_multicycle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, inValid, srcALU, cmpSet, outReady;
  logic [15:0] read1Data, read2Data, immediateExt;
  logic [2:0]  xOp;
  logic [1:0]  cmpOp;
  int          curW;

  logic        inValid16, inReady16, outValid16, err16, busy16;
  logic [15:0] XOut16;
  logic        inValid8, inReady8, outValid8, err8, busy8;
  logic [7:0]  XOut8;

  logic        inReady, outValid, err, busy;
  logic [15:0] XOut;

  int errors = 0;
  int checks = 0;

  execute_multicycle #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .inValid(inValid16), .inReady(inReady16),
    .read1Data(read1Data), .read2Data(read2Data), .immediateExt(immediateExt),
    .srcALU(srcALU), .xOp(xOp), .cmpSet(cmpSet), .cmpOp(cmpOp),
    .outValid(outValid16), .outReady(outReady), .XOut(XOut16), .err(err16), .busy(busy16)
  );

  execute_multicycle #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .inValid(inValid8), .inReady(inReady8),
    .read1Data(read1Data[7:0]), .read2Data(read2Data[7:0]), .immediateExt(immediateExt[7:0]),
    .srcALU(srcALU), .xOp(xOp), .cmpSet(cmpSet), .cmpOp(cmpOp),
    .outValid(outValid8), .outReady(outReady), .XOut(XOut8), .err(err8), .busy(busy8)
  );

  always_comb begin
    inValid16 = inValid && (curW == 16);
    inValid8  = inValid && (curW == 8);
    if (curW == 8) begin
      inReady = inReady8; outValid = outValid8; XOut = {8'h00, XOut8}; err = err8; busy = busy8;
    end else begin
      inReady = inReady16; outValid = outValid16; XOut = XOut16; err = err16; busy = busy16;
    end
  end

  typedef struct {
    string       name;
    logic [15:0] a, b, imm;
    logic        src;
    logic [2:0]  op;
    logic        cs;
    logic [1:0]  co;
    logic [15:0] expX;
    logic        expE;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(string n, logic [15:0] a, logic [15:0] b, logic [15:0] imm, logic src,
                              logic [2:0] op, logic cs, logic [1:0] co, logic [15:0] expX, logic expE);
    vec_t v;
    v.name = n; v.a = a; v.b = b; v.imm = imm; v.src = src; v.op = op;
    v.cs = cs; v.co = co; v.expX = expX; v.expE = expE;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic [15:0] a, logic [15:0] b, logic [15:0] imm, logic src,
                       logic [2:0] op, logic cs, logic [1:0] co);
    read1Data = a; read2Data = b; immediateExt = imm;
    srcALU = src; xOp = op; cmpSet = cs; cmpOp = co;
  endtask

  // Called at the negedge right after an iterative op was accepted.
  task automatic waitMulti(string tag, logic [15:0] expX);
    for (int k = 0; k <= 16; k++) begin
      check({tag, "_busy"}, busy, 1);
      check({tag, "_inReady_low"}, inReady, 0);
      check({tag, "_outValid_low"}, outValid, 0);
      @(negedge clk);
    end
    check({tag, "_outValid"}, outValid, 1);
    check({tag, "_XOut"}, XOut, expX);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy_done"}, busy, 0);
  endtask

  // Independent reference: returns {err, result} for a given width.
  function automatic logic [16:0] model(int w, logic [15:0] a, logic [15:0] b, logic [15:0] imm,
                                        logic cs, logic [1:0] co, logic [2:0] op);
    longint m  = (longint'(1) << w) - 1;
    longint hm = (longint'(1) << (w / 2)) - 1;
    longint ai = longint'(a) & m;
    longint bi = longint'(b) & m;
    longint ii = longint'(imm) & m;
    longint sa = (ai >= (longint'(1) << (w - 1))) ? ai - (longint'(1) << w) : ai;
    longint sb = (bi >= (longint'(1) << (w - 1))) ? bi - (longint'(1) << w) : bi;
    longint r  = 0;
    logic   e  = 1'b0;
    if (cs) begin
      case (co)
        2'b00:   r = (ai == bi) ? 1 : 0;
        2'b01:   r = (sa < sb) ? 1 : 0;
        2'b10:   r = (sa <= sb) ? 1 : 0;
        default: r = ((ai + bi) >> w) & 1;
      endcase
    end else begin
      case (op)
        3'd0: r = (ai + bi) & m;
        3'd1: r = (ai - bi) & m;
        3'd2: r = ai & bi;
        3'd3: r = ai ^ bi;
        3'd4: for (int i = 0; i < w; i++) r = r | (((ai >> i) & 1) << (w - 1 - i));
        3'd5: r = ((ai & hm) << (w / 2)) | (ii & hm);
        3'd6: r = (ai * bi) & m;
        default: begin
`ifdef EXEC_DIV_EN
          if (bi == 0) begin r = m; e = 1'b1; end
          else r = ai / bi;
`else
          r = 0; e = 1'b1;
`endif
        end
      endcase
    end
    return {e, r[15:0]};
  endfunction

  task automatic runRandom(int w, int cycles);
    logic [16:0] q[$];
    logic [16:0] exp;
    logic [15:0] bsel;
    int          cyc = 0;
    curW = w;
    while (cyc < cycles + 300) begin
      @(negedge clk);
      if (cyc < cycles) begin
        inValid      = ($urandom_range(0, 2) != 0);
        outReady     = ($urandom_range(0, 3) != 0);
        read1Data    = 16'($urandom);
        read2Data    = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        immediateExt = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        srcALU       = 1'($urandom_range(0, 1));
        xOp          = 3'($urandom_range(0, 7));
        cmpSet       = ($urandom_range(0, 3) == 0);
        cmpOp        = 2'($urandom_range(0, 3));
      end else begin
        inValid  = 1'b0;
        outReady = 1'b1;
      end
      #1;
      if (outValid && outReady) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rand%0d_extra_result actual=%0h required=none", w, XOut);
        end else begin
          exp = q.pop_front();
          check($sformatf("rand%0d_XOut", w), XOut, {16'h0, exp[15:0]});
          check($sformatf("rand%0d_err", w), err, exp[16]);
        end
      end
      if (inValid && inReady) begin
        bsel = srcALU ? immediateExt : read2Data;
        q.push_back(model(w, read1Data, bsel, immediateExt, cmpSet, cmpOp, xOp));
      end
      cyc++;
      if (cyc >= cycles && q.size() == 0 && !busy && !outValid) break;
    end
    check($sformatf("rand%0d_pending", w), q.size(), 0);
  endtask

  initial begin
    rst = 1'b1; inValid = 1'b0; outReady = 1'b1; curW = 16;
    drive(16'h0, 16'h0, 16'h0, 1'b0, 3'd0, 1'b0, 2'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_outValid", outValid, 0);
    check("rst_busy", busy, 0);
    check("rst_inReady", inReady, 0);
    check("rst_XOut", XOut, 0);
    check("rst_err", err, 0);
    rst = 1'b0;
    #1 check("post_rst_inReady", inReady, 1);

    vecs[0]  = mk("add",      16'h7FFF, 16'h0001, 16'h0000, 0, 3'd0, 0, 2'd0, 16'h8000, 0);
    vecs[1]  = mk("cmp_lt_f", 16'h7FFF, 16'h0001, 16'h0000, 0, 3'd1, 1, 2'd1, 16'h0000, 0);
    vecs[2]  = mk("sub",      16'h7FFF, 16'h0001, 16'h0000, 0, 3'd1, 0, 2'd0, 16'h7FFE, 0);
    vecs[3]  = mk("and",      16'hF0F0, 16'h0FF0, 16'h0000, 0, 3'd2, 0, 2'd0, 16'h00F0, 0);
    vecs[4]  = mk("xor",      16'hF0F0, 16'h0FF0, 16'h0000, 0, 3'd3, 0, 2'd0, 16'hFF00, 0);
    vecs[5]  = mk("btr1",     16'h0001, 16'h0000, 16'h0000, 0, 3'd4, 0, 2'd0, 16'h8000, 0);
    vecs[6]  = mk("btr2",     16'h00F1, 16'h0000, 16'h0000, 0, 3'd4, 0, 2'd0, 16'h8F00, 0);
    vecs[7]  = mk("slbi",     16'h12AB, 16'h0000, 16'h00CD, 1, 3'd5, 0, 2'd0, 16'hABCD, 0);
    vecs[8]  = mk("cmp_eq",   16'h1234, 16'h1234, 16'h0000, 0, 3'd0, 1, 2'd0, 16'h0001, 0);
    vecs[9]  = mk("cmp_lt_v", 16'h8000, 16'h0001, 16'h0000, 0, 3'd0, 1, 2'd1, 16'h0001, 0);
    vecs[10] = mk("cmp_lt_n", 16'hFFFF, 16'h0001, 16'h0000, 0, 3'd0, 1, 2'd1, 16'h0001, 0);
    vecs[11] = mk("cmp_le_e", 16'h0005, 16'h0005, 16'h0000, 0, 3'd0, 1, 2'd2, 16'h0001, 0);
    vecs[12] = mk("cmp_le_g", 16'h0006, 16'h0005, 16'h0000, 0, 3'd0, 1, 2'd2, 16'h0000, 0);
    vecs[13] = mk("cmp_cy",   16'hFFFF, 16'h0001, 16'h0000, 0, 3'd0, 1, 2'd3, 16'h0001, 0);
    vecs[14] = mk("add_imm",  16'h0010, 16'hFFFF, 16'h0005, 1, 3'd0, 0, 2'd0, 16'h0015, 0);
    vecs[15] = mk("cmp_mul",  16'h0003, 16'h0003, 16'h0000, 0, 3'd6, 1, 2'd0, 16'h0001, 0);
`ifdef EXEC_DIV_EN
    vecs[16] = mk("div0",     16'h00C8, 16'h0000, 16'h0000, 0, 3'd7, 0, 2'd0, 16'hFFFF, 1);
`else
    vecs[16] = mk("div0",     16'h00C8, 16'h0000, 16'h0000, 0, 3'd7, 0, 2'd0, 16'h0000, 1);
`endif

    // Back-to-back: one vector issued per cycle, result checked the cycle after.
    for (int i = 0; i <= 17; i++) begin
      if (i > 0) begin
        check({vecs[i-1].name, "_outValid"}, outValid, 1);
        check({vecs[i-1].name, "_XOut"}, XOut, vecs[i-1].expX);
        check({vecs[i-1].name, "_err"}, err, vecs[i-1].expE);
      end
      if (i < 17) begin
        drive(vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].src, vecs[i].op, vecs[i].cs, vecs[i].co);
        inValid = 1'b1;
        #1 check({vecs[i].name, "_inReady"}, inReady, 1);
      end else begin
        inValid = 1'b0;
      end
      @(negedge clk);
    end

    // MUL: 16 iterations plus DONE, output on the 17th edge.
    drive(16'h0123, 16'h0010, 16'h0000, 0, 3'd6, 0, 2'd0);
    inValid = 1'b1;
    #1 check("mul_accept", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    waitMulti("mul", 16'h1230);

    drive(16'h00C8, 16'h0007, 16'h0000, 0, 3'd7, 0, 2'd0);
    inValid = 1'b1;
    #1 check("div_accept", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
`ifdef EXEC_DIV_EN
    waitMulti("div", 16'h001C);
`else
    check("div_off_XOut", XOut, 16'h0000);
    check("div_off_err", err, 1);
    check("div_off_busy", busy, 0);
`endif

    // Backpressure: result held stable while outReady=0.
    @(negedge clk);
    outReady = 1'b0;
    drive(16'h12AB, 16'h0000, 16'h00CD, 1, 3'd5, 0, 2'd0);
    inValid = 1'b1;
    #1 check("hold_accept", inReady, 1);
    @(negedge clk);
    drive(16'h0001, 16'h0002, 16'h0000, 0, 3'd0, 0, 2'd0);
    for (int k = 0; k < 5; k++) begin
      #1;
      check("hold_outValid", outValid, 1);
      check("hold_XOut", XOut, 16'hABCD);
      check("hold_inReady", inReady, 0);
      @(negedge clk);
    end
    outReady = 1'b1;
    #1 check("release_inReady", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    check("release_XOut", XOut, 16'h0003);
    check("release_outValid", outValid, 1);

    // Reset in the middle of a multiply.
    drive(16'h0123, 16'h0010, 16'h0000, 0, 3'd6, 0, 2'd0);
    inValid = 1'b1;
    #1 check("rstmul_accept", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    repeat (7) @(negedge clk);
    check("rstmul_busy_before", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmul_outValid", outValid, 0);
    check("rstmul_busy", busy, 0);
    check("rstmul_XOut", XOut, 0);
    check("rstmul_err", err, 0);
    check("rstmul_inReady", inReady, 0);
    rst = 1'b0;
    drive(16'h0002, 16'h0003, 16'h0000, 0, 3'd0, 0, 2'd0);
    inValid = 1'b1;
    #1 check("rstmul_inReady_after", inReady, 1);
    @(negedge clk);
    inValid = 1'b0;
    check("rstmul_add_XOut", XOut, 16'h0005);
    check("rstmul_add_outValid", outValid, 1);
    repeat (20) @(negedge clk);
    check("rstmul_no_stale", outValid, 0);

    runRandom(16, 400);
    runRandom(8, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
